// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: D->E->M->W instruction/PC register chain with load-use
// stall, E-stage flush, E operand forwarding selects and a saturating stall counter.
module pipe_hazard_ctrl #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr_F,
  input  logic [31:0]      pc_F,
  input  logic             valid_F,
  input  logic             flush_E,
  output logic [31:0]      instr_D,
  output logic [31:0]      instr_E,
  output logic [31:0]      instr_M,
  output logic [31:0]      instr_W,
  output logic [31:0]      pc_D,
  output logic [31:0]      pc_E,
  output logic [31:0]      pc_M,
  output logic [31:0]      pc_W,
  output logic             stall,
  output logic [1:0]       fwdA_E,
  output logic [1:0]       fwdB_E,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // stage slots inside the packed chain
  localparam int SD = 0;
  localparam int SE = 1;
  localparam int SM = 2;
  localparam int SW = 3;

  logic [3:0][31:0]  instr_q, instr_d;
  logic [3:0][31:0]  pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  function automatic logic writes_f(input logic [31:0] i);
    return (i[6:0] inside {OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR})
           && (i[11:7] != 5'd0);
  endfunction

  function automatic logic uses_rs1_f(input logic [31:0] i);
    return i[6:0] inside {OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR};
  endfunction

  function automatic logic uses_rs2_f(input logic [31:0] i);
    return i[6:0] inside {OPC_OP, OPC_STORE, OPC_BRANCH};
  endfunction

  // M beats W; a load sitting in M has no data yet, so it never forwards
  function automatic logic [1:0] fwd_f(input logic [4:0] src, input logic used,
                                       input logic [31:0] i_m, input logic [31:0] i_w);
    if (!used || src == 5'd0)                                        return 2'b00;
    if (writes_f(i_m) && i_m[6:0] != OPC_LOAD && i_m[11:7] == src)   return 2'b01;
    if (writes_f(i_w) && i_w[11:7] == src)                           return 2'b10;
    return 2'b00;
  endfunction

  // load in E feeding a consumer in D; a flush kills both so no stall then
  always_comb begin
    stall = (instr_q[SE][6:0] == OPC_LOAD) && writes_f(instr_q[SE]) && !flush_E &&
            ((uses_rs1_f(instr_q[SD]) && instr_q[SD][19:15] == instr_q[SE][11:7]) ||
             (uses_rs2_f(instr_q[SD]) && instr_q[SD][24:20] == instr_q[SE][11:7]));
  end

  // operand selects for the instruction currently in E
  always_comb begin
    fwdA_E = fwd_f(instr_q[SE][19:15], uses_rs1_f(instr_q[SE]), instr_q[SM], instr_q[SW]);
    fwdB_E = fwd_f(instr_q[SE][24:20], uses_rs2_f(instr_q[SE]), instr_q[SM], instr_q[SW]);
  end

  // next chain state: M/W always advance; flush > stall > normal for D/E
  always_comb begin
    instr_d     = instr_q;
    pc_d        = pc_q;
    instr_d[SW] = instr_q[SM];
    pc_d[SW]    = pc_q[SM];
    instr_d[SM] = instr_q[SE];
    pc_d[SM]    = pc_q[SE];
    if (flush_E) begin
      instr_d[SD] = NOP_INSTR;
      pc_d[SD]    = '0;
      instr_d[SE] = NOP_INSTR;
      pc_d[SE]    = '0;
    end else if (stall) begin
      instr_d[SE] = NOP_INSTR;
      pc_d[SE]    = '0;
    end else begin
      instr_d[SD] = valid_F ? instr_F : NOP_INSTR;
      pc_d[SD]    = valid_F ? pc_F : 32'd0;
      instr_d[SE] = instr_q[SD];
      pc_d[SE]    = pc_q[SD];
    end
    cnt_d = cnt_q;
    if (stall && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
  end

  // state registers, cleared asynchronously to bubbles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= {4{NOP_INSTR}};
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign instr_D   = instr_q[SD];
  assign instr_E   = instr_q[SE];
  assign instr_M   = instr_q[SM];
  assign instr_W   = instr_q[SW];
  assign pc_D      = pc_q[SD];
  assign pc_E      = pc_q[SE];
  assign pc_M      = pc_q[SM];
  assign pc_W      = pc_q[SW];
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed hazard scenarios plus random traffic, all
// outputs compared every cycle against a stage-array reference model.
module tb_pipe_hazard_ctrl;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          CW  = 8;   // narrow counter so saturation is reachable quickly

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   instr_F, pc_F;
  logic          valid_F, flush_E;
  logic [31:0]   instr_D, instr_E, instr_M, instr_W;
  logic [31:0]   pc_D, pc_E, pc_M, pc_W;
  logic          stall;
  logic [1:0]    fwdA_E, fwdB_E;
  logic [CW-1:0] stall_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  // reference: index 0..3 = D,E,M,W
  logic [31:0] mi[4];
  logic [31:0] mp[4];
  int          mcnt;

  pipe_hazard_ctrl #(.NOP_INSTR(NOP), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .instr_F(instr_F), .pc_F(pc_F), .valid_F(valid_F),
    .flush_E(flush_E), .instr_D(instr_D), .instr_E(instr_E), .instr_M(instr_M),
    .instr_W(instr_W), .pc_D(pc_D), .pc_E(pc_E), .pc_M(pc_M), .pc_W(pc_W),
    .stall(stall), .fwdA_E(fwdA_E), .fwdB_E(fwdB_E), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic bit m_wr(input logic [31:0] i);
    return (i[6:0] inside {7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67}) && i[11:7] != 0;
  endfunction
  function automatic bit m_u1(input logic [31:0] i);
    return i[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
  endfunction
  function automatic bit m_u2(input logic [31:0] i);
    return i[6:0] inside {7'h33, 7'h23, 7'h63};
  endfunction

  function automatic bit m_stall();
    logic [31:0] d, e;
    d = mi[0];
    e = mi[1];
    return !flush_E && e[6:0] == 7'h03 && m_wr(e) &&
           ((m_u1(d) && d[19:15] == e[11:7]) || (m_u2(d) && d[24:20] == e[11:7]));
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] s, input bit used);
    if (!used || s == 0) return 2'b00;
    if (m_wr(mi[2]) && mi[2][6:0] != 7'h03 && mi[2][11:7] == s) return 2'b01;
    if (m_wr(mi[3]) && mi[3][11:7] == s) return 2'b10;
    return 2'b00;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 4; k++) begin
      mi[k] = NOP;
      mp[k] = 0;
    end
    mcnt = 0;
  endtask

  task automatic cmp_model();
    logic [31:0] gi[4];
    logic [31:0] gp[4];
    gi = '{instr_D, instr_E, instr_M, instr_W};
    gp = '{pc_D, pc_E, pc_M, pc_W};
    chk("stall", {31'd0, stall}, {31'd0, m_stall()});
    chk("fwdA", {30'd0, fwdA_E}, {30'd0, m_fwd(mi[1][19:15], m_u1(mi[1]))});
    chk("fwdB", {30'd0, fwdB_E}, {30'd0, m_fwd(mi[1][24:20], m_u2(mi[1]))});
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("instr%0d", k), gi[k], mi[k]);
      chk($sformatf("pc%0d", k), gp[k], mp[k]);
    end
    chk("stall_cnt", {{(32-CW){1'b0}}, stall_cnt}, mcnt[31:0]);
  endtask

  task automatic chk_reset_vals();
    chk("rst_iD", instr_D, NOP);
    chk("rst_iE", instr_E, NOP);
    chk("rst_iM", instr_M, NOP);
    chk("rst_iW", instr_W, NOP);
    chk("rst_pc", pc_D | pc_E | pc_M | pc_W, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_fwd", {28'd0, fwdA_E, fwdB_E}, 32'd0);
    chk("rst_cnt", {{(32-CW){1'b0}}, stall_cnt}, 32'd0);
  endtask

  // check current outputs, advance the model across one posedge, return at negedge
  task automatic tick();
    logic [31:0] ni[4];
    logic [31:0] np[4];
    bit st;
    #1;
    cmp_model();
    st = m_stall();
    ni = mi;
    np = mp;
    ni[3] = mi[2]; np[3] = mp[2];
    ni[2] = mi[1]; np[2] = mp[1];
    if (flush_E) begin
      ni[0] = NOP; np[0] = 0; ni[1] = NOP; np[1] = 0;
    end else if (st) begin
      ni[1] = NOP; np[1] = 0;
    end else begin
      ni[0] = valid_F ? instr_F : NOP;
      np[0] = valid_F ? pc_F : 32'd0;
      ni[1] = mi[0]; np[1] = mp[0];
    end
    if (st && mcnt < (1 << CW) - 1) mcnt++;
    @(posedge clk);
    mi = ni;
    mp = np;
    @(negedge clk);
  endtask

  task automatic set_in(input logic [31:0] i, input logic v, input logic f);
    instr_F = i;
    pc_F    = $urandom;
    valid_F = v;
    flush_E = f;
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [6:0] ops[10];
    logic [31:0] r;
    ops = '{7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h23, 7'h63, 7'h73};
    r = $urandom;
    return {r[31:25], 2'b00, r[2:0], 2'b00, r[5:3], r[14:12], 2'b00, r[8:6],
            ops[$urandom_range(9)]};
  endfunction

  localparam logic [31:0] I_ADD  = 32'h003100B3;  // add x1,x2,x3
  localparam logic [31:0] I_SUB  = 32'h40508233;  // sub x4,x1,x5
  localparam logic [31:0] I_LW   = 32'h00032283;  // lw x5,0(x6)
  localparam logic [31:0] I_ADD2 = 32'h008283B3;  // add x7,x5,x8
  localparam logic [31:0] I_ADDI = 32'h00500013;  // addi x0,x0,5
  localparam logic [31:0] I_AX0  = 32'h000000B3;  // add x1,x0,x0
  localparam logic [31:0] I_LWC  = 32'h0002A283;  // lw x5,0(x5): self-dependent load chain

  initial begin
    int c0;
    reset = 1'b1;
    set_in($urandom, 1'($urandom), 1'($urandom));
    m_reset();
    #12;
    chk_reset_vals();
    @(negedge clk);
    reset = 1'b0;

    // ALU -> ALU forwarding from M
    set_in(I_ADD, 1, 0); tick();
    set_in(I_SUB, 1, 0); tick();
    set_in(NOP, 1, 0);   tick();
    #1;
    chk("alu_instrE", instr_E, I_SUB);
    chk("alu_fwdA", {30'd0, fwdA_E}, 32'd1);
    chk("alu_fwdB", {30'd0, fwdB_E}, 32'd0);
    tick();
    chk("alu_nopE", instr_E, NOP);
    chk("alu_fwdA_nop", {30'd0, fwdA_E}, 32'd0);

    // load-use: one stall cycle, then W forwarding
    set_in(I_LW, 1, 0);   tick();
    set_in(I_ADD2, 1, 0); tick();
    set_in(NOP, 1, 0);
    #1;
    chk("lu_stall", {31'd0, stall}, 32'd1);
    c0 = mcnt;
    tick();
    chk("lu_stall_off", {31'd0, stall}, 32'd0);
    chk("lu_holdD", instr_D, I_ADD2);
    chk("lu_bubbleE", instr_E, NOP);
    tick();
    chk("lu_addE", instr_E, I_ADD2);
    chk("lu_fwdA", {30'd0, fwdA_E}, 32'd2);
    chk("lu_cnt", {{(32-CW){1'b0}}, stall_cnt}, 32'(c0 + 1));

    // flush wins over a pending load-use stall
    set_in(I_LW, 1, 0);   tick();
    set_in(I_ADD2, 1, 0); tick();
    set_in(NOP, 1, 1);
    #1;
    chk("fl_stall", {31'd0, stall}, 32'd0);
    c0 = mcnt;
    tick();
    set_in(NOP, 1, 0);
    chk("fl_D", instr_D, NOP);
    chk("fl_E", instr_E, NOP);
    chk("fl_M", instr_M, I_LW);
    chk("fl_cnt", {{(32-CW){1'b0}}, stall_cnt}, 32'(c0));

    // x0 never forwards; valid_F low injects a bubble
    set_in(I_ADDI, 1, 0); tick();
    set_in(I_AX0, 1, 0);  tick();
    set_in(NOP, 1, 0);    tick();
    #1;
    chk("x0_instrE", instr_E, I_AX0);
    chk("x0_fwd", {28'd0, fwdA_E, fwdB_E}, 32'd0);
    set_in(32'h00A00093, 0, 0); tick();
    chk("bubble_D", instr_D, NOP);

    // saturation via a chain of self-dependent loads
    set_in(I_LWC, 1, 0);
    repeat (600) tick();
    chk("sat_cnt", {{(32-CW){1'b0}}, stall_cnt}, 32'((1 << CW) - 1));

    // asynchronous reset between edges
    set_in(I_LWC, 1, 0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals();
    m_reset();
    @(negedge clk);
    reset = 1'b0;

    // random traffic: small register set to make hazards common
    repeat (1500) begin
      set_in(rnd_instr(), 1'($urandom_range(9) < 8), 1'($urandom_range(9) == 0));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Instruction/PC pipeline register chain D→E→M→W. Feeds instr_E, instr_M and instr_W to the per-stage control decoders, and instr_D to the ID decoder.
- Detects load-use hazards and stalls; applies branch/jump flush; generates E-stage operand forwarding selects.
- Keeps a saturating stall counter for performance debug.

Parameters:
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0).
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- instr_F  in  32  fetched instruction.
- pc_F  in  32  PC of instr_F.
- valid_F  in  1  instr_F valid. Low means fetch not ready: insert bubble into D.
- flush_E  in  1  branch/jump taken, resolved in E.
- instr_D, instr_E, instr_M, instr_W  out  32  stage instruction registers.
- pc_D, pc_E, pc_M, pc_W  out  32  stage PC registers.
- stall  out  1  combinational. Holds PC/IF and the D register.
- fwdA_E, fwdB_E  out  2  E operand select: 00 regfile, 01 M ALU result, 10 W write data.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted:
  - all instr_* = NOP_INSTR; all pc_* = 0; stall_cnt = 0.
  - consequently stall = 0, fwdA_E = fwdB_E = 00.
- Field decode per RV32I: opcode [6:0], rd [11:7], rs1 [19:15], rs2 [24:20].
- writes(i): opcode ∈ {OP 0110011, OP-IMM 0010011, LOAD 0000011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111} and rd ≠ 0.
- uses_rs1(i): opcode ∈ {OP, OP-IMM, LOAD, STORE 0100011, BRANCH 1100011, JALR}.
- uses_rs2(i): opcode ∈ {OP, STORE, BRANCH}.
- Load-use hazard: stall = (opcode_E == LOAD) & writes(instr_E) & ((uses_rs1(instr_D) & rs1_D == rd_E) | (uses_rs2(instr_D) & rs2_D == rd_E)) & ~flush_E.
- Per-cycle register update, in priority order:
  1. flush_E=1: instr_D ← NOP, instr_E ← NOP, M ← E, W ← M. pc_D/pc_E load 0. Any stall condition is ignored.
  2. stall=1: D holds (instr_D, pc_D), instr_E ← NOP (pc_E ← 0), M ← E, W ← M.
  3. Otherwise: D ← (valid_F ? instr_F : NOP), with pc_D ← pc_F or 0. E ← D, M ← E, W ← M.
- Latency with no stall or flush: instr_F appears on instr_D after 1 cycle and on instr_W after 4 cycles.
- Forwarding (combinational from registered state), evaluated per source s ∈ {rs1_E → fwdA, rs2_E → fwdB}:
  - Only when uses_rs*(instr_E) and s ≠ 0.
  - 01 if writes(instr_M), opcode_M ≠ LOAD and rd_M == s.
  - Else 10 if writes(instr_W) and rd_W == s.
  - Else 00. M has priority over W.
- A LOAD in M never forwards (01). The load-use stall guarantees the consumer sees it from W (10).
- stall_cnt increments by 1 on every clock edge where stall=1, and saturates at 2^CNT_W−1 (no wrap).
- valid_F is ignored while stall=1 or flush_E=1. F is held by stall or discarded by flush.
- Reset asserted mid-operation clears everything immediately. The first edge after deassertion behaves as the normal no-stall path.

Test Plan:
- Reset: assert reset with random inputs → all instr_* = 32'h00000013, pc_* = 0, stall = 0, fwd = 00, stall_cnt = 0.
- ALU→ALU forward: feed 0x003100B3 (add x1,x2,x3) then 0x40508233 (sub x4,x1,x5) with valid_F=1 → when sub is in E, fwdA_E = 01, fwdB_E = 00. One cycle later, 0x00000013 (nop) is in E and fwdA_E = 00.
- Load-use: 0x00032283 (lw x5,0(x6)) then 0x008283B3 (add x7,x5,x8) →
  - stall = 1 for exactly one cycle; instr_D holds 0x008283B3; instr_E becomes NOP.
  - Next cycle add is in E with fwdA_E = 10; stall_cnt = 1.
- Flush over stall: create the load-use condition and assert flush_E the same cycle → stall = 0; next cycle instr_D = instr_E = NOP, instr_M = the lw; stall_cnt unchanged.
- x0 and bubble: 0x00500013 (addi x0,x0,5) then 0x000000B3 (add x1,x0,x0) → fwdA_E = fwdB_E = 00. valid_F=0 for one cycle → NOP enters D.
- Saturation/reset: force 2^16+3 stall cycles → stall_cnt = 16'hFFFF. Assert reset asynchronously between edges → all outputs return to reset values before the next clk edge.
